regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 38 +++
 rtl/regfile_mp.sv | 100 ++++++++++
 tb/tb_regfile_mp.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_pkg;

  localparam int DEFAULT_DATA_W   = 8;
  localparam int DEFAULT_NUM_REGS = 8;
  localparam int DEFAULT_NUM_RD   = 2;

  // Default-shaped view of the packed read-data bus, one element per port.
  typedef logic [DEFAULT_NUM_RD-1:0][DEFAULT_DATA_W-1:0] rd_data_vec_t;

  function automatic logic addr_in_range(input int addr, input int num_regs);
    return (addr >= 0) && (addr < num_regs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set by producer issue, cleared by the matching write.
// Exposes the post-update vector so readers see this cycle's set/clear.
module regfile_scoreboard #(
  parameter  int NUM_REGS = 8,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_addr,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  output logic [NUM_REGS-1:0] pending_next
);

  logic [NUM_REGS-1:0] pending;

  // Set is applied after clear so a same-cycle reissue keeps the bit high.
  always_comb begin
    pending_next = pending;
    if (clr_en) begin
      pending_next[clr_addr] = 1'b0;
    end
    if (set_en) begin
      pending_next[set_addr] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with hardwired-zero r0 and a pending-bit scoreboard.
// Define REGFILE_BYPASS_EN for write-first forwarding; default is read-first.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = DEFAULT_DATA_W,
  parameter  int NUM_REGS = DEFAULT_NUM_REGS,
  parameter  int NUM_RD   = DEFAULT_NUM_RD,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr
);

  // Out-of-range addresses alias to r0, which has no storage.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] a);
    return addr_in_range(int'(a), NUM_REGS) ? a : '0;
  endfunction

  logic [DATA_W-1:0]               regs [1:NUM_REGS-1];
  logic [ADDR_W-1:0]               wr_idx;
  logic [ADDR_W-1:0]               sb_idx;
  logic                            wr_hit;
  logic                            sb_hit;
  logic [NUM_REGS-1:0]             pending_next;
  logic [NUM_RD-1:0][ADDR_W-1:0]   rd_idx;
  logic [NUM_RD-1:0][DATA_W-1:0]   rd_data_next;
  logic [NUM_RD-1:0]               rd_busy_next;

  assign wr_idx = map_addr(wr_addr);
  assign sb_idx = map_addr(sb_addr);
  assign wr_hit = wr_en && (wr_idx != '0);
  assign sb_hit = sb_set && (sb_idx != '0);

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .set_en       (sb_hit),
    .set_addr     (sb_idx),
    .clr_en       (wr_hit),
    .clr_addr     (wr_idx),
    .pending_next (pending_next)
  );

  always_ff @(posedge clk) begin
    for (int i = 1; i < NUM_REGS; i++) begin
      if (reset) begin
        regs[i] <= '0;
      end else if (wr_hit && (wr_idx == ADDR_W'(i))) begin
        regs[i] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_idx       = '0;
    rd_data_next = '0;
    rd_busy_next = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_idx[p] = map_addr(rd_addr[p*ADDR_W +: ADDR_W]);
      for (int i = 1; i < NUM_REGS; i++) begin
        if (rd_idx[p] == ADDR_W'(i)) begin
          rd_data_next[p] = regs[i];
        end
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && (rd_idx[p] == wr_idx)) begin
        rd_data_next[p] = wr_data;
      end
`endif
      rd_busy_next[p] = pending_next[rd_idx[p]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_en[p]) begin
          rd_data[p*DATA_W +: DATA_W] <= rd_data_next[p];
          rd_busy[p]                  <= rd_busy_next[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default instance (8 regs) and a 6-register instance.
module tb_regfile_mp;
  import regfile_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic       b;
  } exp_t;

  localparam exp_t Z = '0;
`ifdef REGFILE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  rd_en_a, rd_busy_a, rd_en_b, rd_busy_b;
  logic [5:0]  rd_addr_a, rd_addr_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic        wr_en_a, sb_set_a, wr_en_b, sb_set_b;
  logic [2:0]  wr_addr_a, sb_addr_a, wr_addr_b, sb_addr_b;
  logic [7:0]  wr_data_a, wr_data_b;
  rd_data_vec_t rdv_a, rdv_b;

  assign rdv_a = rd_data_a;
  assign rdv_b = rd_data_b;

  regfile_mp dut_a (
    .clk(clk), .reset(reset),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .sb_set(sb_set_a), .sb_addr(sb_addr_a)
  );

  regfile_mp #(.NUM_REGS(6)) dut_b (
    .clk(clk), .reset(reset),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .sb_set(sb_set_b), .sb_addr(sb_addr_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] chk_a = '0, chk_b = '0, chk_a_q = '0, chk_b_q = '0;
  exp_t qa0[$], qa1[$], qb0[$], qb1[$];

  task automatic check(input string nm, input logic [7:0] ad, input logic ab, input exp_t e);
    n_tests++;
    if (ad !== e.d || ab !== e.b) begin
      n_fail++;
      $display("FAIL %s: got data=%h busy=%b, expected data=%h busy=%b", nm, ad, ab, e.d, e.b);
    end
  endtask

  task automatic no_exp(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: output checked with nothing expected in queue", nm);
  endtask

  // Monitor: compares the outputs produced by the previous edge against queued expectations.
  always @(posedge clk) begin
    chk_a_q <= chk_a;
    chk_b_q <= chk_b;
  end

  always @(negedge clk) begin
    if (chk_a_q[0]) begin
      if (qa0.size() == 0) no_exp("a.p0"); else check("a.p0", rdv_a[0], rd_busy_a[0], qa0.pop_front());
    end
    if (chk_a_q[1]) begin
      if (qa1.size() == 0) no_exp("a.p1"); else check("a.p1", rdv_a[1], rd_busy_a[1], qa1.pop_front());
    end
    if (chk_b_q[0]) begin
      if (qb0.size() == 0) no_exp("b.p0"); else check("b.p0", rdv_b[0], rd_busy_b[0], qb0.pop_front());
    end
    if (chk_b_q[1]) begin
      if (qb1.size() == 0) no_exp("b.p1"); else check("b.p1", rdv_b[1], rd_busy_b[1], qb1.pop_front());
    end
  end

  task automatic step_a(input logic rst, input logic [1:0] en, input logic [2:0] a0, input logic [2:0] a1,
                        input logic we, input logic [2:0] wa, input logic [7:0] wd,
                        input logic ss, input logic [2:0] sa,
                        input logic [1:0] chk, input exp_t e0, input exp_t e1);
    reset = rst;
    rd_en_a = en; rd_addr_a = {a1, a0};
    wr_en_a = we; wr_addr_a = wa; wr_data_a = wd;
    sb_set_a = ss; sb_addr_a = sa;
    rd_en_b = '0; rd_addr_b = '0; wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
    sb_set_b = 1'b0; sb_addr_b = '0;
    chk_a = chk; chk_b = '0;
    if (chk[0]) qa0.push_back(e0);
    if (chk[1]) qa1.push_back(e1);
    @(negedge clk);
  endtask

  task automatic step_b(input logic [1:0] en, input logic [2:0] a0, input logic [2:0] a1,
                        input logic we, input logic [2:0] wa, input logic [7:0] wd,
                        input logic ss, input logic [2:0] sa,
                        input logic [1:0] chk, input exp_t e0, input exp_t e1);
    reset = 1'b0;
    rd_en_b = en; rd_addr_b = {a1, a0};
    wr_en_b = we; wr_addr_b = wa; wr_data_b = wd;
    sb_set_b = ss; sb_addr_b = sa;
    rd_en_a = '0; rd_addr_a = '0; wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
    sb_set_a = 1'b0; sb_addr_a = '0;
    chk_b = chk; chk_a = '0;
    if (chk[0]) qb0.push_back(e0);
    if (chk[1]) qb1.push_back(e1);
    @(negedge clk);
  endtask

  initial begin
    // reset clears outputs on both instances
    step_a(1, 2'b00, 0, 0, 0, 0, 8'h00, 0, 0, 2'b11, Z, Z);
    step_a(0, 2'b00, 0, 0, 1, 3, 8'hA5, 0, 0, 2'b00, Z, Z);
    step_a(0, 2'b01, 3, 0, 0, 0, 8'h00, 0, 0, 2'b01, {8'hA5, 1'b0}, Z);
    // same-cycle write/read of r5
    step_a(0, 2'b11, 3, 5, 1, 5, 8'h3C, 0, 0, 2'b11, {8'hA5, 1'b0}, BYP ? exp_t'({8'h3C, 1'b0}) : Z);
    step_a(0, 2'b10, 0, 5, 0, 0, 8'h00, 0, 0, 2'b10, Z, {8'h3C, 1'b0});
    // scoreboard on r2
    step_a(0, 2'b00, 0, 0, 0, 0, 8'h00, 1, 2, 2'b00, Z, Z);
    step_a(0, 2'b01, 2, 0, 0, 0, 8'h00, 0, 0, 2'b01, {8'h00, 1'b1}, Z);
    step_a(0, 2'b00, 0, 0, 1, 2, 8'h11, 0, 0, 2'b00, Z, Z);
    step_a(0, 2'b01, 2, 0, 0, 0, 8'h00, 0, 0, 2'b01, {8'h11, 1'b0}, Z);
    step_a(0, 2'b10, 0, 2, 1, 2, 8'h22, 1, 2, 2'b10, Z,
           BYP ? exp_t'({8'h22, 1'b1}) : exp_t'({8'h11, 1'b1}));
    step_a(0, 2'b01, 2, 0, 0, 0, 8'h00, 0, 0, 2'b01, {8'h22, 1'b1}, Z);
    step_a(0, 2'b01, 2, 0, 1, 2, 8'h33, 0, 0, 2'b01,
           BYP ? exp_t'({8'h33, 1'b0}) : exp_t'({8'h22, 1'b0}), Z);
    // r0 ignores writes and sb_set
    step_a(0, 2'b00, 0, 0, 1, 0, 8'hFF, 1, 0, 2'b00, Z, Z);
    step_a(0, 2'b11, 0, 0, 0, 0, 8'h00, 0, 0, 2'b11, Z, Z);
    // fill r1..r7, r6 holds 0x5A
    for (int i = 1; i < 8; i++)
      step_a(0, 2'b00, 0, 0, 1, 3'(i), (i == 6) ? 8'h5A : 8'(8'h10 + i), 0, 0, 2'b00, Z, Z);
    step_a(0, 2'b00, 0, 0, 0, 0, 8'h00, 1, 4, 2'b00, Z, Z);
    step_a(0, 2'b11, 4, 7, 0, 0, 8'h00, 0, 0, 2'b11, {8'h14, 1'b1}, {8'h17, 1'b0});
    step_a(0, 2'b11, 6, 6, 0, 0, 8'h00, 0, 0, 2'b11, {8'h5A, 1'b0}, {8'h5A, 1'b0});
    // rd_en low: outputs hold despite new addresses
    step_a(0, 2'b00, 1, 7, 0, 0, 8'h00, 0, 0, 2'b11, {8'h5A, 1'b0}, {8'h5A, 1'b0});
    // reset wins over a concurrent write, sb_set and read
    step_a(1, 2'b11, 3, 5, 1, 4, 8'h77, 1, 2, 2'b11, Z, Z);
    for (int i = 1; i < 8; i++)
      step_a(0, 2'b11, 3'(i), 3'(8 - i), 0, 0, 8'h00, 0, 0, 2'b11, Z, Z);

    // 6-register instance: addresses 6 and 7 alias to r0
    step_b(2'b00, 0, 0, 1, 5, 8'hAB, 0, 0, 2'b00, Z, Z);
    step_b(2'b00, 0, 0, 1, 7, 8'hEE, 0, 0, 2'b00, Z, Z);
    step_b(2'b00, 0, 0, 1, 6, 8'hDD, 0, 0, 2'b00, Z, Z);
    step_b(2'b00, 0, 0, 0, 0, 8'h00, 1, 7, 2'b00, Z, Z);
    step_b(2'b00, 0, 0, 0, 0, 8'h00, 1, 6, 2'b00, Z, Z);
    step_b(2'b11, 5, 7, 0, 0, 8'h00, 0, 0, 2'b11, {8'hAB, 1'b0}, Z);
    step_b(2'b11, 6, 0, 0, 0, 8'h00, 0, 0, 2'b11, Z, Z);
    for (int i = 1; i < 5; i++)
      step_b(2'b11, 3'(i), 5, 0, 0, 8'h00, 0, 0, 2'b11, Z, {8'hAB, 1'b0});

    step_b(2'b00, 0, 0, 0, 0, 8'h00, 0, 0, 2'b00, Z, Z);
    step_b(2'b00, 0, 0, 0, 0, 8'h00, 0, 0, 2'b00, Z, Z);

    n_tests++;
    if (qa0.size() + qa1.size() + qb0.size() + qb1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0",
               qa0.size() + qa1.size() + qb0.size() + qb1.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
